// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin wormhole arbiter for one router output port.
// Holds the grant from head to tail flit and forwards flits through a registered stage.
module output_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_IN     = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN-1:0]            req,
  input  logic [NUM_IN-1:0]            in_valid,
  input  logic [NUM_IN-1:0]            in_tail,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic                         ret,
  output logic [NUM_IN-1:0]            grant,
  output logic [NUM_IN-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  output logic                         busy,
  output logic [15:0]                  flit_cnt
);
  localparam int PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t                  r_state, w_next;
  logic [NUM_IN-1:0]       r_grant;
  logic [PW-1:0]           r_ptr;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic                    r_out_valid;
  logic [15:0]             r_flit_cnt;
  logic [PW-1:0]           w_gidx, w_pick;
  logic                    w_xfer, w_tail;
  logic [DATA_WIDTH-1:0]   w_flit;
  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (r_grant[i]) w_gidx = PW'(i);
  end
  // Descending scan so the nearest requester after r_ptr wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx    = '0;
    w_pick = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      idx = PW'((int'(r_ptr) + k) % NUM_IN);
      if (req[idx]) w_pick = idx;
    end
  end
  assign w_flit = in_data[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_tail = in_tail[w_gidx];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = |req ? LOCKED : IDLE;
    else                 w_next = (w_xfer && w_tail) ? IDLE : LOCKED;
  end
  always_comb begin
    busy     = r_state == LOCKED;
    w_xfer   = busy && in_valid[w_gidx] && !ret;
    in_ready = r_grant & {NUM_IN{w_xfer}};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant     <= '0;
      r_ptr       <= PW'(NUM_IN - 1);
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_flit_cnt  <= '0;
    end else begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= w_flit;
        r_flit_cnt <= r_flit_cnt + 16'd1;
      end
      if (r_state == IDLE && |req) begin
        r_grant <= NUM_IN'(1) << w_pick;
      end else if (w_xfer && w_tail) begin
        r_grant <= '0;
        r_ptr   <= w_gidx;
      end
    end
  end
  assign grant     = r_grant;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign flit_cnt  = r_flit_cnt;
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: directed per-cycle vector table plus a counter-wrap sequence.
module tb_output_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  req, in_valid, in_tail, grant, in_ready;
  logic [39:0] in_data;
  logic        ret, out_valid, busy;
  logic [7:0]  out_data;
  logic [15:0] flit_cnt;
  int          n_cmp = 0;
  int          n_err = 0;
  output_port_arbiter #(.DATA_WIDTH(8), .NUM_IN(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .in_valid(in_valid), .in_tail(in_tail),
    .in_data(in_data), .ret(ret), .grant(grant), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .flit_cnt(flit_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        rn;
    logic [4:0]  rq, vl, tl;
    logic [39:0] d;
    logic        rt;
    logic [4:0]  g, rd;
    logic        ov;
    logic [7:0]  od;
    logic        bz;
    logic [15:0] c;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(input logic rn, input logic [4:0] rq, input logic [4:0] vl,
                              input logic [4:0] tl, input logic [39:0] d, input logic rt,
                              input logic [4:0] g, input logic [4:0] rd, input logic ov,
                              input logic [7:0] od, input logic bz, input logic [15:0] c);
    vec_t v;
    v.rn = rn; v.rq = rq; v.vl = vl; v.tl = tl; v.d = d; v.rt = rt;
    v.g = g; v.rd = rd; v.ov = ov; v.od = od; v.bz = bz; v.c = c;
    return v;
  endfunction
  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask
  initial begin
    // reset
    tbl.push_back(mk(0,5'b00000,5'b00000,5'b00000,40'h0,0, 5'b00000,5'b00000,0,8'h00,0,16'd0));
    // single 3-flit packet on input 2
    tbl.push_back(mk(1,5'b00100,5'b00000,5'b00000,40'h0,0, 5'b00000,5'b00000,0,8'h00,0,16'd0));
    tbl.push_back(mk(1,5'b00100,5'b00100,5'b00000,40'h0000110000,0, 5'b00100,5'b00100,0,8'h00,1,16'd0));
    tbl.push_back(mk(1,5'b00100,5'b00100,5'b00000,40'h0000220000,0, 5'b00100,5'b00100,1,8'h11,1,16'd1));
    tbl.push_back(mk(1,5'b00100,5'b00100,5'b00100,40'h0000330000,0, 5'b00100,5'b00100,1,8'h22,1,16'd2));
    tbl.push_back(mk(1,5'b00000,5'b00000,5'b00000,40'h0,0, 5'b00000,5'b00000,1,8'h33,0,16'd3));
    tbl.push_back(mk(1,5'b00000,5'b00000,5'b00000,40'h0,0, 5'b00000,5'b00000,0,8'h33,0,16'd3));
    // round robin with all requesting single-flit packets
    tbl.push_back(mk(0,5'b11111,5'b00000,5'b00000,40'h0,0, 5'b00000,5'b00000,0,8'h00,0,16'd0));
    tbl.push_back(mk(1,5'b11111,5'b11111,5'b11111,40'hA4A3A2A1A0,0, 5'b00000,5'b00000,0,8'h00,0,16'd0));
    tbl.push_back(mk(1,5'b11111,5'b11111,5'b11111,40'hA4A3A2A1A0,0, 5'b00001,5'b00001,0,8'h00,1,16'd0));
    tbl.push_back(mk(1,5'b11111,5'b11111,5'b11111,40'hA4A3A2A1A0,0, 5'b00000,5'b00000,1,8'hA0,0,16'd1));
    tbl.push_back(mk(1,5'b11111,5'b11111,5'b11111,40'hA4A3A2A1A0,0, 5'b00010,5'b00010,0,8'hA0,1,16'd1));
    tbl.push_back(mk(1,5'b11111,5'b11111,5'b11111,40'hA4A3A2A1A0,0, 5'b00000,5'b00000,1,8'hA1,0,16'd2));
    tbl.push_back(mk(1,5'b11111,5'b11111,5'b11111,40'hA4A3A2A1A0,0, 5'b00100,5'b00100,0,8'hA1,1,16'd2));
    tbl.push_back(mk(1,5'b11111,5'b11111,5'b11111,40'hA4A3A2A1A0,0, 5'b00000,5'b00000,1,8'hA2,0,16'd3));
    tbl.push_back(mk(1,5'b11111,5'b11111,5'b11111,40'hA4A3A2A1A0,0, 5'b01000,5'b01000,0,8'hA2,1,16'd3));
    tbl.push_back(mk(1,5'b11111,5'b11111,5'b11111,40'hA4A3A2A1A0,0, 5'b00000,5'b00000,1,8'hA3,0,16'd4));
    tbl.push_back(mk(1,5'b11111,5'b11111,5'b11111,40'hA4A3A2A1A0,0, 5'b10000,5'b10000,0,8'hA3,1,16'd4));
    tbl.push_back(mk(1,5'b11111,5'b11111,5'b11111,40'hA4A3A2A1A0,0, 5'b00000,5'b00000,1,8'hA4,0,16'd5));
    tbl.push_back(mk(1,5'b11111,5'b11111,5'b11111,40'hA4A3A2A1A0,0, 5'b00001,5'b00001,0,8'hA4,1,16'd5));
    // backpressure: ret held 4 cycles after flit 1 of 3 on input 1
    tbl.push_back(mk(1,5'b00010,5'b00010,5'b00000,40'h000000B100,0, 5'b00000,5'b00000,1,8'hA0,0,16'd6));
    tbl.push_back(mk(1,5'b00010,5'b00010,5'b00000,40'h000000B100,0, 5'b00010,5'b00010,0,8'hA0,1,16'd6));
    tbl.push_back(mk(1,5'b00010,5'b00010,5'b00000,40'h000000B200,1, 5'b00010,5'b00000,1,8'hB1,1,16'd7));
    tbl.push_back(mk(1,5'b00010,5'b00010,5'b00000,40'h000000B200,1, 5'b00010,5'b00000,0,8'hB1,1,16'd7));
    tbl.push_back(mk(1,5'b00010,5'b00010,5'b00000,40'h000000B200,1, 5'b00010,5'b00000,0,8'hB1,1,16'd7));
    tbl.push_back(mk(1,5'b00010,5'b00010,5'b00000,40'h000000B200,1, 5'b00010,5'b00000,0,8'hB1,1,16'd7));
    tbl.push_back(mk(1,5'b00010,5'b00010,5'b00000,40'h000000B200,0, 5'b00010,5'b00010,0,8'hB1,1,16'd7));
    tbl.push_back(mk(1,5'b00010,5'b00010,5'b00010,40'h000000B300,0, 5'b00010,5'b00010,1,8'hB2,1,16'd8));
    // lock hold: input 3 requests while input 1 owns the port
    tbl.push_back(mk(1,5'b00010,5'b00010,5'b00000,40'h000000C100,0, 5'b00000,5'b00000,1,8'hB3,0,16'd9));
    tbl.push_back(mk(1,5'b01010,5'b01010,5'b01000,40'h00D100C100,0, 5'b00010,5'b00010,0,8'hB3,1,16'd9));
    tbl.push_back(mk(1,5'b01010,5'b01010,5'b01010,40'h00D100C200,0, 5'b00010,5'b00010,1,8'hC1,1,16'd10));
    tbl.push_back(mk(1,5'b01000,5'b01000,5'b01000,40'h00D1000000,0, 5'b00000,5'b00000,1,8'hC2,0,16'd11));
    tbl.push_back(mk(1,5'b01000,5'b01000,5'b01000,40'h00D1000000,0, 5'b01000,5'b01000,0,8'hC2,1,16'd11));
    tbl.push_back(mk(1,5'b00000,5'b00000,5'b00000,40'h0,0, 5'b00000,5'b00000,1,8'hD1,0,16'd12));
    // async reset mid-packet, then 10001 grants input 0 first
    tbl.push_back(mk(1,5'b00100,5'b00100,5'b00000,40'h0000E10000,0, 5'b00000,5'b00000,0,8'hD1,0,16'd12));
    tbl.push_back(mk(1,5'b00100,5'b00100,5'b00000,40'h0000E10000,0, 5'b00100,5'b00100,0,8'hD1,1,16'd12));
    tbl.push_back(mk(0,5'b00100,5'b00100,5'b00000,40'h0000E20000,0, 5'b00000,5'b00000,0,8'h00,0,16'd0));
    tbl.push_back(mk(1,5'b10001,5'b10001,5'b10001,40'hF4000000F0,0, 5'b00000,5'b00000,0,8'h00,0,16'd0));
    tbl.push_back(mk(1,5'b10001,5'b10001,5'b10001,40'hF4000000F0,0, 5'b00001,5'b00001,0,8'h00,1,16'd0));
    tbl.push_back(mk(1,5'b10001,5'b10001,5'b10001,40'hF4000000F0,0, 5'b00000,5'b00000,1,8'hF0,0,16'd1));
    tbl.push_back(mk(1,5'b10001,5'b10001,5'b10001,40'hF4000000F0,0, 5'b10000,5'b10000,0,8'hF0,1,16'd1));
    tbl.push_back(mk(1,5'b00000,5'b00000,5'b00000,40'h0,0, 5'b00000,5'b00000,1,8'hF4,0,16'd2));
    rst_n = 1'b0; req = '0; in_valid = '0; in_tail = '0; in_data = '0; ret = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n = tbl[i].rn; req = tbl[i].rq; in_valid = tbl[i].vl; in_tail = tbl[i].tl;
      in_data = tbl[i].d; ret = tbl[i].rt;
      #1;
      chk("grant",     i, 16'(grant),     16'(tbl[i].g));
      chk("in_ready",  i, 16'(in_ready),  16'(tbl[i].rd));
      chk("out_valid", i, 16'(out_valid), 16'(tbl[i].ov));
      chk("out_data",  i, 16'(out_data),  16'(tbl[i].od));
      chk("busy",      i, 16'(busy),      16'(tbl[i].bz));
      chk("flit_cnt",  i, flit_cnt,       tbl[i].c);
    end
    // counter wrap: one endless packet on input 0
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; req = 5'b00001; in_valid = 5'b00001; in_tail = '0; in_data = 40'h55; ret = 1'b0;
    @(posedge clk);
    repeat (65535) @(posedge clk);
    @(negedge clk);
    chk("cnt_max",   900, flit_cnt, 16'hFFFF);
    chk("wrap_busy", 901, 16'(busy), 16'd1);
    @(negedge clk);
    chk("cnt_wrap",  902, flit_cnt, 16'h0000);
    chk("wrap_ov",   903, 16'(out_valid), 16'd1);
    chk("wrap_od",   904, 16'(out_data), 16'h0055);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
